// File: rtl/izh_sweep_scheduler.sv
// izh_sweep_scheduler
// Shares one external, purely combinational Izhikevich Euler-update datapath
// across NUM_NEURONS virtual neurons. Per-neuron v/u, a/b shifts and stimulus
// current live in a local register file. Each tick sweeps every neuron through
// the datapath and queues spiking neuron indices in a small event FIFO.
// Optional build macro: IZH_REFRACT_EN adds a per-neuron refractory counter
// that zeroes the stimulus current for REFRACT_TICKS updates after a spike.
//
// state | meaning
// IDLE  | waiting for tick_i
// LOAD  | latch operands of neuron r_idx onto dp_*
// WRITE | datapath settles; write back v/u, queue spike event
// DONE  | sweep_done_o pulse, then back to IDLE
module izh_sweep_scheduler #(
    parameter int NUM_NEURONS   = 4,
    parameter int IDX_W         = $clog2(NUM_NEURONS),
    parameter int FIFO_DEPTH    = 4,
    parameter int REFRACT_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             tick_i,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [7:0]       cfg_data,
    output logic [17:0]      dp_v,
    output logic [17:0]      dp_u,
    output logic [3:0]       dp_a,
    output logic [3:0]       dp_b,
    output logic [17:0]      dp_i,
    input  logic [17:0]      dp_v_next,
    input  logic [17:0]      dp_u_next,
    input  logic             dp_spike,
    output logic             busy_o,
    output logic             sweep_done_o,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_idx,
    output logic             overrun_o,
    output logic             ev_lost_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // -0.7 and -0.2 in 2.16 fixed point
    localparam logic [17:0] V_RST = 18'h3_4CCD;
    localparam logic [17:0] U_RST = 18'h3_CCCD;
    localparam logic [3:0]  A_RST = 4'd6;
    localparam logic [3:0]  B_RST = 4'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;

    logic [17:0] r_v   [NUM_NEURONS];
    logic [17:0] r_u   [NUM_NEURONS];
    logic [3:0]  r_a   [NUM_NEURONS];
    logic [3:0]  r_b   [NUM_NEURONS];
    logic [7:0]  r_cur [NUM_NEURONS];

    logic [17:0] r_dp_v;
    logic [17:0] r_dp_u;
    logic [17:0] r_dp_i;
    logic [3:0]  r_dp_a;
    logic [3:0]  r_dp_b;

    logic [IDX_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic r_overrun;
    logic r_lost;

    logic        w_last;
    logic        w_cfg_hit;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_push_ok;
    logic [3:0]  w_a_src;
    logic [3:0]  w_b_src;
    logic [7:0]  w_cur_src;
    logic [17:0] w_i_src;

`ifdef IZH_REFRACT_EN
    localparam int REF_W = $clog2(REFRACT_TICKS + 1);
    logic [REF_W-1:0] r_refr [NUM_NEURONS];
`else
    logic w_unused_refract;
    assign w_unused_refract = (REFRACT_TICKS != 0);
`endif

    assign w_last    = (r_idx == IDX_W'(NUM_NEURONS - 1));
    assign w_cfg_hit = ena && cfg_we && (cfg_addr == r_idx);

    assign w_push    = ena && (r_state == S_WRITE) && dp_spike;
    assign w_pop     = ena && ev_valid && ev_ready;
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push_ok = w_push && (!w_full || w_pop);

    // Operand sources for the LOAD latch; a config write landing on the same
    // edge that ends LOAD is forwarded so the latched operands include it.
    always_comb begin
        w_a_src   = r_a[r_idx];
        w_b_src   = r_b[r_idx];
        w_cur_src = r_cur[r_idx];
        if (w_cfg_hit) begin
            if (cfg_sel) begin
                w_cur_src = cfg_data;
            end else begin
                w_a_src = cfg_data[3:0];
                w_b_src = cfg_data[7:4];
            end
        end
        w_i_src = {w_cur_src, 10'h0FF};
`ifdef IZH_REFRACT_EN
        if (r_refr[r_idx] != '0) begin
            w_i_src = '0;
        end
`endif
    end

    // Sweep sequencer and datapath operand registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_dp_v  <= '0;
            r_dp_u  <= '0;
            r_dp_i  <= '0;
            r_dp_a  <= '0;
            r_dp_b  <= '0;
        end else if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (tick_i) begin
                        r_state <= S_LOAD;
                        r_idx   <= '0;
                    end
                end
                S_LOAD: begin
                    r_dp_v  <= r_v[r_idx];
                    r_dp_u  <= r_u[r_idx];
                    r_dp_a  <= w_a_src;
                    r_dp_b  <= w_b_src;
                    r_dp_i  <= w_i_src;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-neuron register file: config writes plus v/u writeback in WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                r_v[n]   <= V_RST;
                r_u[n]   <= U_RST;
                r_a[n]   <= A_RST;
                r_b[n]   <= B_RST;
                r_cur[n] <= '0;
`ifdef IZH_REFRACT_EN
                r_refr[n] <= '0;
`endif
            end
        end else if (ena) begin
            if (cfg_we) begin
                if (cfg_sel) begin
                    r_cur[cfg_addr] <= cfg_data;
                end else begin
                    r_a[cfg_addr] <= cfg_data[3:0];
                    r_b[cfg_addr] <= cfg_data[7:4];
                end
            end
            if (r_state == S_WRITE) begin
                r_v[r_idx] <= dp_v_next;
                r_u[r_idx] <= dp_u_next;
`ifdef IZH_REFRACT_EN
                if (dp_spike) begin
                    r_refr[r_idx] <= REF_W'(REFRACT_TICKS);
                end else if (r_refr[r_idx] != '0) begin
                    r_refr[r_idx] <= r_refr[r_idx] - REF_W'(1);
                end
`endif
            end
        end
    end

    // Spike event FIFO; a push into a full FIFO survives only alongside a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int n = 0; n < FIFO_DEPTH; n++) begin
                r_mem[n] <= '0;
            end
        end else if (ena) begin
            if (w_push_ok) begin
                r_mem[r_wr] <= r_idx;
                r_wr        <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            if (ena && tick_i && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_push && !w_push_ok) begin
                r_lost <= 1'b1;
            end
        end
    end

    assign dp_v         = r_dp_v;
    assign dp_u         = r_dp_u;
    assign dp_a         = r_dp_a;
    assign dp_b         = r_dp_b;
    assign dp_i         = r_dp_i;
    assign busy_o       = (r_state != S_IDLE);
    assign sweep_done_o = (r_state == S_DONE);
    assign ev_valid     = (r_count != '0);
    assign ev_idx       = r_mem[r_rd];
    assign overrun_o    = r_overrun;
    assign ev_lost_o    = r_lost;

endmodule
